// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline plus the IF/ID pipeline register.
// Holds the PC, chooses the next PC from PCSource/HazardControl and latches
// {instruction, PC+4} for decode. All outputs come straight from registers.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0008,
  parameter logic [31:0] NOP        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HazardControl,
  input  logic [2:0]  PCSource,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] JrTarget,
  input  logic [31:0] Instruction_in,
  output logic [31:0] PC_out,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC_Plus4,
  output logic        IF_ID_Valid,
  output logic [15:0] StallCount
);

  logic        hard_redir;
  logic        soft_redir;
  logic [31:0] redir_target;
  logic [31:0] pc_plus4;

  assign pc_plus4 = PC_out + 32'd4;

  // Classify PCSource and pick the redirect target. Hard redirects (branch
  // resolved in EX, IRQ, exception) beat a stall because the stalled ID
  // instruction is on the wrong path; soft ones (jr/j from ID) wait it out.
  always_comb begin
    hard_redir   = 1'b0;
    soft_redir   = 1'b0;
    redir_target = 32'h0;
    case (PCSource)
      3'b001: begin hard_redir = 1'b1; redir_target = BranchTarget; end
      3'b100: begin hard_redir = 1'b1; redir_target = IRQ_VECTOR;   end
      3'b101: begin hard_redir = 1'b1; redir_target = EXC_VECTOR;   end
      3'b010: begin soft_redir = 1'b1; redir_target = JrTarget;     end
      3'b011: begin soft_redir = 1'b1; redir_target = JumpTarget;   end
      default: ;  // 000, 110, 111: sequential
    endcase
    // Targets are always word aligned.
    redir_target[1:0] = 2'b00;
  end

  // PC, IF/ID register and stall counter; priority reset > hard > stall > soft > seq.
  always_ff @(posedge clk) begin
    if (reset) begin
      PC_out            <= RESET_PC;
      IF_ID_Instruction <= NOP;
      IF_ID_PC_Plus4    <= 32'h0;
      IF_ID_Valid       <= 1'b0;
      StallCount        <= 16'h0;
    end else if (hard_redir) begin
      PC_out            <= redir_target;
      IF_ID_Instruction <= NOP;
      IF_ID_PC_Plus4    <= 32'h0;
      IF_ID_Valid       <= 1'b0;
    end else if (HazardControl) begin
      // PC and IF/ID hold; a pending jr/j is taken once the stall lifts.
      if (StallCount != 16'hFFFF) StallCount <= StallCount + 16'd1;
    end else if (soft_redir) begin
      // Instruction fetched this cycle is wrong path: drop it as a bubble.
      PC_out            <= redir_target;
      IF_ID_Instruction <= NOP;
      IF_ID_PC_Plus4    <= 32'h0;
      IF_ID_Valid       <= 1'b0;
    end else begin
      PC_out            <= pc_plus4;
      IF_ID_Instruction <= Instruction_in;
      IF_ID_PC_Plus4    <= pc_plus4;
      IF_ID_Valid       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage. Instruction memory is modelled
// as a tag function of the address so each latched word identifies its PC.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        HazardControl;
  logic [2:0]  PCSource;
  logic [31:0] BranchTarget, JumpTarget, JrTarget;
  logic [31:0] Instruction_in;
  logic [31:0] PC_out, IF_ID_Instruction, IF_ID_PC_Plus4;
  logic        IF_ID_Valid;
  logic [15:0] StallCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .HazardControl    (HazardControl),
    .PCSource         (PCSource),
    .BranchTarget     (BranchTarget),
    .JumpTarget       (JumpTarget),
    .JrTarget         (JrTarget),
    .Instruction_in   (Instruction_in),
    .PC_out           (PC_out),
    .IF_ID_Instruction(IF_ID_Instruction),
    .IF_ID_PC_Plus4   (IF_ID_PC_Plus4),
    .IF_ID_Valid      (IF_ID_Valid),
    .StallCount       (StallCount)
  );

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Instruction memory: read data for the current fetch address.
  assign Instruction_in = tag(PC_out);

  typedef struct {
    logic        rst;
    logic        hz;
    logic [2:0]  src;
    logic [31:0] br;
    logic [31:0] jmp;
    logic [31:0] jr;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic [31:0] e_pc4;
    logic        e_v;
    logic [15:0] e_sc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic hz, input logic [2:0] src,
                     input logic [31:0] br, input logic [31:0] jmp, input logic [31:0] jr,
                     input logic [31:0] e_pc, input logic [31:0] e_ins,
                     input logic [31:0] e_pc4, input logic e_v, input logic [15:0] e_sc);
    vec_t v;
    v.rst = rst; v.hz = hz; v.src = src; v.br = br; v.jmp = jmp; v.jr = jr;
    v.e_pc = e_pc; v.e_ins = e_ins; v.e_pc4 = e_pc4; v.e_v = e_v; v.e_sc = e_sc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [31:0] e_pc, input logic [31:0] e_ins,
                         input logic [31:0] e_pc4, input logic e_v, input logic [15:0] e_sc);
    chk($sformatf("v%0d PC_out", idx), PC_out, e_pc);
    chk($sformatf("v%0d IF_ID_Instruction", idx), IF_ID_Instruction, e_ins);
    chk($sformatf("v%0d IF_ID_PC_Plus4", idx), IF_ID_PC_Plus4, e_pc4);
    chk($sformatf("v%0d IF_ID_Valid", idx), {31'h0, IF_ID_Valid}, {31'h0, e_v});
    chk($sformatf("v%0d StallCount", idx), {16'h0, StallCount}, {16'h0, e_sc});
  endtask

  initial begin
    reset = 1'b1; HazardControl = 1'b0; PCSource = 3'b000;
    BranchTarget = 32'h0; JumpTarget = 32'h0; JrTarget = 32'h0;

    //   rst hz src     br            jmp           jr            pc             ins                 pc4            v  sc
    // reset held 3 cycles, then sequential fetch
    add(1, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 16'd0);
    add(1, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 16'd0);
    add(1, 0, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 16'd0);
    add(0, 0, 3'b000, 0, 0, 0, 32'h4, tag(32'h0), 32'h4, 1, 16'd0);
    add(0, 0, 3'b000, 0, 0, 0, 32'h8, tag(32'h4), 32'h8, 1, 16'd0);
    // two stall cycles at PC=8, then resume
    add(0, 1, 3'b000, 0, 0, 0, 32'h8, tag(32'h4), 32'h8, 1, 16'd1);
    add(0, 1, 3'b000, 0, 0, 0, 32'h8, tag(32'h4), 32'h8, 1, 16'd2);
    add(0, 0, 3'b000, 0, 0, 0, 32'hC, tag(32'h8), 32'hC, 1, 16'd2);
    // jr held off by a stall, taken next cycle with target aligned
    add(0, 1, 3'b010, 0, 0, 32'h103, 32'hC, tag(32'h8), 32'hC, 1, 16'd3);
    add(0, 0, 3'b010, 0, 0, 32'h103, 32'h100, 32'h0, 32'h0, 0, 16'd3);
    add(0, 0, 3'b000, 0, 0, 0, 32'h104, tag(32'h100), 32'h104, 1, 16'd3);
    // branch overrides stall, no stall counted
    add(0, 1, 3'b001, 32'h40, 0, 0, 32'h40, 32'h0, 32'h0, 0, 16'd3);
    add(0, 0, 3'b000, 0, 0, 0, 32'h44, tag(32'h40), 32'h44, 1, 16'd3);
    // j to 0x20, exception there, then vector instr
    add(0, 0, 3'b011, 0, 32'h20, 0, 32'h20, 32'h0, 32'h0, 0, 16'd3);
    add(0, 0, 3'b101, 0, 0, 0, 32'h8000_0008, 32'h0, 32'h0, 0, 16'd3);
    add(0, 0, 3'b000, 0, 0, 0, 32'h8000_000C, tag(32'h8000_0008), 32'h8000_000C, 1, 16'd3);
    // IRQ, then 110 behaves as sequential
    add(0, 0, 3'b100, 0, 0, 0, 32'h8000_0004, 32'h0, 32'h0, 0, 16'd3);
    add(0, 0, 3'b110, 32'h500, 32'h600, 32'h700, 32'h8000_0008, tag(32'h8000_0004), 32'h8000_0008, 1, 16'd3);
    // misaligned jump to top of memory, then wrap
    add(0, 0, 3'b011, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 0, 16'd3);
    add(0, 0, 3'b000, 0, 0, 0, 32'h0, tag(32'hFFFF_FFFC), 32'h0, 1, 16'd3);
    // stall, then reset asserted mid-stall
    add(0, 1, 3'b000, 0, 0, 0, 32'h0, tag(32'hFFFF_FFFC), 32'h0, 1, 16'd4);
    add(1, 1, 3'b000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 16'd0);
    add(0, 0, 3'b000, 0, 0, 0, 32'h4, tag(32'h0), 32'h4, 1, 16'd0);
    // 111 behaves as sequential
    add(0, 0, 3'b111, 32'h900, 0, 0, 32'h8, tag(32'h4), 32'h8, 1, 16'd0);
    // misaligned branch target
    add(0, 0, 3'b001, 32'h202, 0, 0, 32'h200, 32'h0, 32'h0, 0, 16'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; HazardControl = vecs[i].hz; PCSource = vecs[i].src;
      BranchTarget = vecs[i].br; JumpTarget = vecs[i].jmp; JrTarget = vecs[i].jr;
      @(posedge clk); #1;
      chk_all(i, vecs[i].e_pc, vecs[i].e_ins, vecs[i].e_pc4, vecs[i].e_v, vecs[i].e_sc);
    end

    // Long stall: counter saturates at FFFF, PC and IF/ID hold.
    @(negedge clk);
    HazardControl = 1'b1; PCSource = 3'b000;
    repeat (65540) @(posedge clk);
    #1;
    chk_all(900, 32'h200, 32'h0, 32'h0, 1'b0, 16'hFFFF);

    // Hard redirect under stall while saturated: taken, counter unchanged.
    @(negedge clk);
    PCSource = 3'b001; BranchTarget = 32'h300;
    @(posedge clk); #1;
    chk_all(901, 32'h300, 32'h0, 32'h0, 1'b0, 16'hFFFF);

    // Release: sequential fetch from the branch target.
    @(negedge clk);
    HazardControl = 1'b0; PCSource = 3'b000;
    @(posedge clk); #1;
    chk_all(902, 32'h304, tag(32'h300), 32'h304, 1'b1, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
